// File: rtl/dff_skid_pkg.sv
// rtl/dff_skid_pkg.sv - state encoding shared by the skid slice
package dff_skid_pkg;

    // Occupancy and state share one encoding, so level is the state register itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/dff_sren.sv
// rtl/dff_sren.sv - data flop with synchronous active-high reset and enable
module dff_sren #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_skid_slice.sv
// rtl/dff_skid_slice.sv - two-entry registered valid/ready slice; optional DFF_SKID_FLUSH_EN adds flush
module dff_skid_slice
    import dff_skid_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef DFF_SKID_FLUSH_EN
    input  logic                  flush,
`endif
    output logic [1:0]            level
);

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] out_d;
    logic                  out_en;
    logic                  skid_en;
    logic                  in_fire;
    logic                  out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign level    = state_q;

    always_comb begin
        state_d = state_q;
        out_en  = 1'b0;
        skid_en = 1'b0;
        out_d   = in_data;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    out_en  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    out_en = 1'b1;
                end else if (in_fire) begin
                    skid_en = 1'b1;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    out_en  = 1'b1;
                    out_d   = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
`ifdef DFF_SKID_FLUSH_EN
        // Flush empties the slice but leaves the data registers untouched.
        if (flush) begin
            state_d = ST_EMPTY;
            out_en  = 1'b0;
            skid_en = 1'b0;
        end
`endif
    end

    // in_ready is held low on reset so it rises on the first edge after release.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d != ST_EMPTY);
            in_ready  <= (state_d != ST_FULL);
        end
    end

    dff_sren #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VALUE(RESET_VALUE)
    ) u_out_reg (
        .clock (clock),
        .reset (reset),
        .enable(out_en),
        .d     (out_d),
        .q     (out_data)
    );

    dff_sren #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VALUE(RESET_VALUE)
    ) u_skid_reg (
        .clock (clock),
        .reset (reset),
        .enable(skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_dff_skid_slice.sv
// tb/tb_dff_skid_slice.sv - scoreboard bench for dff_skid_slice; flush scenario under DFF_SKID_FLUSH_EN
module tb_dff_skid_slice;

    localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  level;
`ifdef DFF_SKID_FLUSH_EN
    logic        flush;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_q[$];
    logic        m_rdy = 1'b0;

    always #5 clock = ~clock;

    dff_skid_slice #(
        .DATA_WIDTH (32),
        .RESET_VALUE(RST_VAL)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef DFF_SKID_FLUSH_EN
        .flush    (flush),
`endif
        .level    (level)
    );

    // Drives one cycle at the negedge and advances the reference queue model.
    task automatic tick(input logic iv, input logic [31:0] d, input logic ordy,
                        input logic fl, input logic rst);
        logic in_f;
        logic out_f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        reset     = rst;
`ifdef DFF_SKID_FLUSH_EN
        flush     = fl;
`endif
        in_f  = iv && m_rdy;
        out_f = (m_q.size() != 0) && ordy;
        @(posedge clock);
        @(negedge clock);
        if (rst) begin
            m_q.delete();
            m_rdy = 1'b0;
        end else if (fl) begin
            m_q.delete();
            m_rdy = 1'b1;
        end else begin
            if (out_f) void'(m_q.pop_front());
            if (in_f) m_q.push_back(d);
            m_rdy = (m_q.size() != 2);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
            total++;
            if (out_valid !== 1'b0 || level !== 2'd0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: valid=%b level=%0d rdy=%b required 0/0/0", out_valid, level, in_ready);
            end
            total++;
            if (out_data !== RST_VAL) begin
                bad++;
                $display("FAIL reset_data: got %h required %h", out_data, RST_VAL);
            end
        end
        tick(1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
        total++;
        if (in_ready !== 1'b1 || level !== 2'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: rdy=%b level=%0d valid=%b required 1/0/0", in_ready, level, out_valid);
        end
    endtask

    task automatic test_streaming;
        for (int i = 1; i <= 16; i++) begin
            if (out_valid) begin
                total++;
                if (m_q.size() == 0 || out_data !== m_q[0]) begin
                    bad++;
                    $display("FAIL stream_pop: got %h", out_data);
                end
            end
            tick(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'(i) || level !== 2'd1 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_out: data=%h valid=%b level=%0d rdy=%b required %h/1/1/1",
                         out_data, out_valid, level, in_ready, 32'(i));
            end
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (level !== 2'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_drain: level=%0d valid=%b required 0/0", level, out_valid);
        end
    endtask

    task automatic test_backpressure;
        tick(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        total++;
        if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            bad++;
            $display("FAIL bp_full: level=%0d rdy=%b data=%h required 2/0/a", level, in_ready, out_data);
        end
        tick(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        total++;
        if (level !== 2'd2 || out_data !== 32'hA) begin
            bad++;
            $display("FAIL bp_hold: level=%0d data=%h required 2/a", level, out_data);
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (out_data !== 32'hB || level !== 2'd1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain1: data=%h level=%0d rdy=%b required b/1/1", out_data, level, in_ready);
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (level !== 2'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain2: level=%0d valid=%b required 0/0", level, out_valid);
        end
    endtask

    task automatic test_random;
        logic        iv;
        logic        ordy;
        logic [31:0] d;
        int          pops = 0;
        for (int i = 0; i < 10000; i++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            d    = $urandom;
            if (out_valid && ordy) begin
                pops++;
                total++;
                if (m_q.size() == 0 || out_data !== m_q[0]) begin
                    bad++;
                    $display("FAIL rand_order: cycle %0d got %h depth %0d", i, out_data, m_q.size());
                end
            end
            tick(iv, d, ordy, 1'b0, 1'b0);
            total++;
            if (level !== 2'(m_q.size()) || out_valid !== (m_q.size() != 0)) begin
                bad++;
                $display("FAIL rand_level: cycle %0d level=%0d valid=%b required depth %0d", i, level, out_valid, m_q.size());
            end
            total++;
            if (in_ready !== m_rdy || (in_ready === 1'b1 && level === 2'd2)) begin
                bad++;
                $display("FAIL rand_ready: cycle %0d rdy=%b level=%0d required %b", i, in_ready, level, m_rdy);
            end
        end
        total++;
        if (pops < 1000) begin
            bad++;
            $display("FAIL rand_throughput: pops=%0d required >= 1000", pops);
        end
        while (m_q.size() != 0) tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        tick(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
        total++;
        if (level !== 2'd2) begin
            bad++;
            $display("FAIL mid_fill: level=%0d required 2", level);
        end
        tick(1'b1, 32'h8, 1'b1, 1'b0, 1'b1);
        total++;
        if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== RST_VAL) begin
            bad++;
            $display("FAIL mid_reset: level=%0d valid=%b data=%h required 0/0/%h", level, out_valid, out_data, RST_VAL);
        end
        tick(1'b1, 32'h7, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h7, 1'b0, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h7 || level !== 2'd1) begin
            bad++;
            $display("FAIL mid_first: data=%h valid=%b level=%0d required 7/1/1", out_data, out_valid, level);
        end
        while (m_q.size() != 0) tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

`ifdef DFF_SKID_FLUSH_EN
    task automatic test_flush;
        tick(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h9, 1'b0, 1'b1, 1'b0);
        total++;
        if (level !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_empty: level=%0d valid=%b rdy=%b required 0/0/1", level, out_valid, in_ready);
        end
        tick(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h11 || level !== 2'd1) begin
            bad++;
            $display("FAIL flush_next: data=%h valid=%b level=%0d required 11/1/1", out_data, out_valid, level);
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (level !== 2'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_drain: level=%0d valid=%b required 0/0 (0x9 must not appear)", level, out_valid);
        end
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
`ifdef DFF_SKID_FLUSH_EN
        flush     = 1'b0;
`endif
        @(negedge clock);
        test_reset;
        test_streaming;
        test_backpressure;
        test_random;
        test_reset_mid;
`ifdef DFF_SKID_FLUSH_EN
        test_flush;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
